// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - instruction handshake and register-file bus for alu_seq_ctrl
interface alu_seq_ctrl_if;
  logic [13:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [6:0]  f_addr;
  logic        f_re;
  logic [7:0]  f_rdata;
  logic        f_we;
  logic [7:0]  f_wdata;

  modport master (
    output instr, instr_valid, f_rdata,
    input  instr_ready, f_addr, f_re, f_we, f_wdata
  );

  modport slave (
    input  instr, instr_valid, f_rdata,
    output instr_ready, f_addr, f_re, f_we, f_wdata
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - five-state sequencer driving an external byte ALU, W and STATUS
module alu_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic          clr,
  output logic          swap_n_mov,
  output logic          rlf_n_rrf,
  output logic          sub,
  output logic [1:0]    op_mux_l,
  output logic [1:0]    op_mux_a,
  output logic [1:0]    out_mux,
  output logic          C_in,
  output logic [7:0]    op_A,
  output logic [7:0]    op_B,
  input  logic [7:0]    alu_result,
  input  logic          C_new,
  input  logic          DC_new,
  input  logic          Z_new,
  output logic [7:0]    w_reg,
  output logic          status_c,
  output logic          status_dc,
  output logic          status_z,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, DEC, RD, EXE, WB} state_t;

  typedef struct packed {
    logic       legal;
    logic       clr;
    logic       swap;
    logic       rlf;
    logic       sub;
    logic [1:0] mux_l;
    logic [1:0] mux_a;
    logic [1:0] out;
    logic       upd_c;
    logic       upd_dc;
    logic       upd_z;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t r;
    r       = '0;
    r.legal = 1'b1;
    case (op)
      6'b000111: begin r.upd_c = 1'b1; r.upd_dc = 1'b1; r.upd_z = 1'b1; end
      6'b000010: begin r.sub = 1'b1; r.mux_a = 2'd1; r.upd_c = 1'b1; r.upd_dc = 1'b1; r.upd_z = 1'b1; end
      6'b001010: begin r.mux_a = 2'd2; r.upd_z = 1'b1; end
      6'b000011: begin r.mux_a = 2'd3; r.upd_z = 1'b1; end
      6'b000100: begin r.out = 2'd1; r.mux_l = 2'd0; r.upd_z = 1'b1; end
      6'b000101: begin r.out = 2'd1; r.mux_l = 2'd1; r.upd_z = 1'b1; end
      6'b000110: begin r.out = 2'd1; r.mux_l = 2'd2; r.upd_z = 1'b1; end
      6'b001001: begin r.out = 2'd1; r.mux_l = 2'd3; r.upd_z = 1'b1; end
      6'b001000: begin r.out = 2'd3; r.upd_z = 1'b1; end
      6'b001110: begin r.out = 2'd3; r.swap = 1'b1; end
      6'b001101: begin r.out = 2'd2; r.rlf = 1'b1; r.upd_c = 1'b1; end
      6'b001100: begin r.out = 2'd2; r.upd_c = 1'b1; end
      6'b000001: begin r.clr = 1'b1; r.upd_z = 1'b1; end
      default:   r = '0;
    endcase
    return r;
  endfunction

  state_t      state_q;
  logic [13:0] instr_q;
  dec_t        ctrl_q;
  dec_t        dec_d;
  logic        ready_q, f_re_q, f_we_q, done_q;
  logic [6:0]  f_addr_q;
  logic [7:0]  f_wdata_q, op_a_q, w_q, res_q;
  logic        c_q, dc_q, z_q, c_new_q, dc_new_q, z_new_q;

  assign dec_d = decode(instr_q[13:8]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      ctrl_q    <= '0;
      ready_q   <= 1'b1;
      f_re_q    <= 1'b0;
      f_we_q    <= 1'b0;
      done_q    <= 1'b0;
      f_addr_q  <= '0;
      f_wdata_q <= '0;
      op_a_q    <= '0;
      w_q       <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      dc_q      <= 1'b0;
      z_q       <= 1'b0;
      c_new_q   <= 1'b0;
      dc_new_q  <= 1'b0;
      z_new_q   <= 1'b0;
    end else begin
      f_re_q <= 1'b0;
      f_we_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.instr_valid && ready_q) begin
            instr_q <= bus.instr;
            ready_q <= 1'b0;
            state_q <= DEC;
          end
        end
        DEC: begin
          f_re_q   <= 1'b1;
          f_addr_q <= instr_q[6:0];
          state_q  <= RD;
        end
        RD: begin
          op_a_q   <= bus.f_rdata;
          f_addr_q <= '0;
          ctrl_q   <= dec_d;
          state_q  <= EXE;
        end
        EXE: begin
          // ALU outputs are frozen here; WB commits only these captured copies
          res_q    <= alu_result;
          c_new_q  <= C_new;
          dc_new_q <= DC_new;
          z_new_q  <= Z_new;
          done_q   <= 1'b1;
          if (ctrl_q.legal && instr_q[7]) begin
            f_we_q    <= 1'b1;
            f_addr_q  <= instr_q[6:0];
            f_wdata_q <= alu_result;
          end
          state_q <= WB;
        end
        WB: begin
          if (ctrl_q.legal && !instr_q[7]) w_q <= res_q;
          if (ctrl_q.upd_c)  c_q  <= c_new_q;
          if (ctrl_q.upd_dc) dc_q <= dc_new_q;
          if (ctrl_q.upd_z)  z_q  <= z_new_q;
          ctrl_q    <= '0;
          f_addr_q  <= '0;
          f_wdata_q <= '0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          ctrl_q  <= '0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.f_addr      = f_addr_q;
  assign bus.f_re        = f_re_q;
  assign bus.f_we        = f_we_q;
  assign bus.f_wdata     = f_wdata_q;

  assign clr        = ctrl_q.clr;
  assign swap_n_mov = ctrl_q.swap;
  assign rlf_n_rrf  = ctrl_q.rlf;
  assign sub        = ctrl_q.sub;
  assign op_mux_l   = ctrl_q.mux_l;
  assign op_mux_a   = ctrl_q.mux_a;
  assign out_mux    = ctrl_q.out;

  assign C_in      = c_q;
  assign op_A      = op_a_q;
  assign op_B      = w_q;
  assign w_reg     = w_q;
  assign status_c  = c_q;
  assign status_dc = dc_q;
  assign status_z  = z_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus ();

  logic       clr, swap_n_mov, rlf_n_rrf, sub;
  logic [1:0] op_mux_l, op_mux_a, out_mux;
  logic       C_in;
  logic [7:0] op_A, op_B, alu_result, w_reg;
  logic       C_new, DC_new, Z_new;
  logic       status_c, status_dc, status_z, done;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .clr(clr), .swap_n_mov(swap_n_mov), .rlf_n_rrf(rlf_n_rrf), .sub(sub),
    .op_mux_l(op_mux_l), .op_mux_a(op_mux_a), .out_mux(out_mux),
    .C_in(C_in), .op_A(op_A), .op_B(op_B),
    .alu_result(alu_result), .C_new(C_new), .DC_new(DC_new), .Z_new(Z_new),
    .w_reg(w_reg), .status_c(status_c), .status_dc(status_dc), .status_z(status_z),
    .done(done)
  );

  localparam logic [5:0] ADDWF = 6'b000111, SUBWF = 6'b000010, INCF = 6'b001010;
  localparam logic [5:0] DECF = 6'b000011, IORWF = 6'b000100, ANDWF = 6'b000101;
  localparam logic [5:0] XORWF = 6'b000110, COMF = 6'b001001, MOVF = 6'b001000;
  localparam logic [5:0] SWAPF = 6'b001110, RLF = 6'b001101, RRF = 6'b001100;
  localparam logic [5:0] CLRF = 6'b000001;

  int total = 0;
  int bad = 0;

  logic [7:0] m_w;
  logic       m_c, m_dc, m_z;
  logic [7:0] m_mem [128];
  logic [5:0] ops [13];

  typedef struct {
    logic [13:0] ins;
    logic [7:0]  w0;
    logic        c0;
    logic [7:0]  fv;
    logic        exp_we;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_w;
    logic        exp_c;
    logic        exp_z;
    logic        chk_dc;
    logic        exp_dc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_now();
    return {clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, out_mux};
  endfunction

  // {clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, out_mux}
  function automatic logic [9:0] spec_ctrl(input logic [5:0] op);
    case (op)
      ADDWF:   return 10'b0000_00_00_00;
      SUBWF:   return 10'b0001_00_01_00;
      INCF:    return 10'b0000_00_10_00;
      DECF:    return 10'b0000_00_11_00;
      IORWF:   return 10'b0000_00_00_01;
      ANDWF:   return 10'b0000_01_00_01;
      XORWF:   return 10'b0000_10_00_01;
      COMF:    return 10'b0000_11_00_01;
      MOVF:    return 10'b0000_00_00_11;
      SWAPF:   return 10'b0100_00_00_11;
      RLF:     return 10'b0010_00_00_10;
      RRF:     return 10'b0000_00_00_10;
      CLRF:    return 10'b1000_00_00_00;
      default: return 10'b0;
    endcase
  endfunction

  // Instruction semantics: result, flags {C,DC,Z} and which flags the instruction affects
  task automatic model_alu(input logic [5:0] op, input logic [7:0] f, output logic [7:0] r,
                           output logic [2:0] flg, output logic [2:0] upd, output logic legal);
    int   s;
    logic c, dc;
    legal = 1'b1;
    upd   = 3'b001;
    c     = 1'b0;
    dc    = 1'b0;
    r     = 8'h00;
    case (op)
      ADDWF: begin
        s = int'(f) + int'(m_w);
        r = 8'(s);
        c = (s > 255);
        dc = (int'(f[3:0]) + int'(m_w[3:0])) > 15;
        upd = 3'b111;
      end
      SUBWF: begin
        r = f - m_w;
        c = (f >= m_w);
        dc = (f[3:0] >= m_w[3:0]);
        upd = 3'b111;
      end
      INCF:  r = f + 8'd1;
      DECF:  r = f - 8'd1;
      IORWF: r = f | m_w;
      ANDWF: r = f & m_w;
      XORWF: r = f ^ m_w;
      COMF:  r = ~f;
      MOVF:  r = f;
      CLRF:  r = 8'h00;
      SWAPF: begin r = {f[3:0], f[7:4]}; upd = 3'b000; end
      RLF:   begin r = {f[6:0], m_c}; c = f[7]; upd = 3'b100; end
      RRF:   begin r = {m_c, f[7:1]}; c = f[0]; upd = 3'b100; end
      default: begin legal = 1'b0; upd = 3'b000; end
    endcase
    flg = {c, dc, r == 8'h00};
  endtask

  task automatic scramble_alu();
    alu_result = 8'($urandom);
    C_new      = 1'($urandom);
    DC_new     = 1'($urandom);
    Z_new      = 1'($urandom);
  endtask

  // Runs one instruction from IDLE (entered at a negedge) back to IDLE, checking every stage
  task automatic exec(input logic [13:0] ins, output logic o_we, output logic [7:0] o_wdata);
    logic [5:0] op;
    logic       d, legal, c0;
    logic [6:0] fa;
    logic [7:0] fv, r, w0;
    logic [2:0] flg, upd;
    logic [9:0] ce;
    op = ins[13:8]; d = ins[7]; fa = ins[6:0];
    fv = m_mem[fa]; w0 = m_w; c0 = m_c;
    model_alu(op, fv, r, flg, upd, legal);
    ce = spec_ctrl(op);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    chk("idle_ready", 32'(bus.instr_ready), 1);
    @(negedge clk);
    bus.instr_valid = 1'($urandom);
    bus.instr = 14'($urandom);
    bus.f_rdata = 8'($urandom);
    scramble_alu();
    chk("dec_ready", 32'(bus.instr_ready), 0);
    chk("dec_f_re", 32'(bus.f_re), 0);
    chk("dec_done", 32'(done), 0);
    @(negedge clk);
    chk("rd_f_re", 32'(bus.f_re), 1);
    chk("rd_f_addr", 32'(bus.f_addr), 32'(fa));
    chk("rd_ctrl", 32'(ctrl_now()), 0);
    bus.f_rdata = fv;
    @(negedge clk);
    chk("exe_ctrl", 32'(ctrl_now()), 32'(ce));
    chk("exe_c_in", 32'(C_in), 32'(c0));
    chk("exe_op_a", 32'(op_A), 32'(fv));
    chk("exe_op_b", 32'(op_B), 32'(w0));
    chk("exe_done", 32'(done), 0);
    chk("exe_f_we", 32'(bus.f_we), 0);
    alu_result = r;
    C_new  = upd[2] ? flg[2] : 1'($urandom);
    DC_new = upd[1] ? flg[1] : 1'($urandom);
    Z_new  = upd[0] ? flg[0] : 1'($urandom);
    @(negedge clk);
    scramble_alu();
    bus.f_rdata = 8'($urandom);
    chk("wb_done", 32'(done), 1);
    chk("wb_f_we", 32'(bus.f_we), 32'(legal && d));
    if (legal && d) begin
      chk("wb_f_addr", 32'(bus.f_addr), 32'(fa));
      chk("wb_f_wdata", 32'(bus.f_wdata), 32'(r));
    end
    chk("wb_ctrl", 32'(ctrl_now()), 32'(ce));
    o_we = bus.f_we;
    o_wdata = bus.f_wdata;
    if (legal) begin
      if (d) m_mem[fa] = r;
      else   m_w = r;
    end
    if (upd[2]) m_c  = flg[2];
    if (upd[1]) m_dc = flg[1];
    if (upd[0]) m_z  = flg[0];
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_f_we", 32'(bus.f_we), 0);
    chk("idle_ready_back", 32'(bus.instr_ready), 1);
    chk("idle_ctrl", 32'(ctrl_now()), 0);
    chk("w_reg", 32'(w_reg), 32'(m_w));
    chk("status", 32'({status_c, status_dc, status_z}), 32'({m_c, m_dc, m_z}));
  endtask

  task automatic set_c(input logic c);
    logic we; logic [7:0] wd;
    m_mem[7'h7E] = c ? 8'h80 : 8'h00;
    exec({RLF, 1'b0, 7'h7E}, we, wd);
  endtask

  task automatic set_w(input logic [7:0] w);
    logic we; logic [7:0] wd;
    m_mem[7'h7F] = w;
    exec({MOVF, 1'b0, 7'h7F}, we, wd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_w = 8'h00; m_c = 1'b0; m_dc = 1'b0; m_z = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic        we;
    logic [7:0]  wd;
    logic [13:0] ins;
    logic [5:0]  op;
    int          xfer [$];
    int          dones;

    ops = '{ADDWF, SUBWF, INCF, DECF, IORWF, ANDWF, XORWF, COMF, MOVF, SWAPF, RLF, RRF, CLRF};
    for (int i = 0; i < 128; i++) m_mem[i] = 8'($urandom);

    //          ins      w0     c0    fv     we    wdata  w      c     z     chkdc dc
    vecs[0] = '{14'h07A0, 8'h0F, 1'b0, 8'h01, 1'b1, 8'h10, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{14'h0221, 8'h05, 1'b0, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{14'h0DA2, 8'h00, 1'b1, 8'h80, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{14'h3FA3, 8'h33, 1'b1, 8'h55, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{14'h01A4, 8'h44, 1'b0, 8'h9C, 1'b1, 8'h00, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{14'h0E25, 8'h12, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{14'h0626, 8'h0F, 1'b0, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{14'h0C27, 8'hFF, 1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{14'h03A8, 8'h10, 1'b1, 8'h01, 1'b1, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{14'h0729, 8'hF0, 1'b0, 8'h20, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.f_rdata = '0;
    alu_result = '0;
    C_new = 1'b0; DC_new = 1'b0; Z_new = 1'b0;

    do_reset();
    chk("rst_ready", 32'(bus.instr_ready), 1);
    chk("rst_w", 32'(w_reg), 0);
    chk("rst_flags", 32'({status_c, status_dc, status_z}), 0);
    chk("rst_f_re", 32'(bus.f_re), 0);
    chk("rst_f_we", 32'(bus.f_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ctrl", 32'(ctrl_now()), 0);
    chk("rst_op_a", 32'(op_A), 0);
    chk("rst_bus", 32'({bus.f_addr, bus.f_wdata}), 0);

    for (int i = 0; i < 10; i++) begin
      m_mem[vecs[i].ins[6:0]] = vecs[i].fv;
      set_c(vecs[i].c0);
      set_w(vecs[i].w0);
      exec(vecs[i].ins, we, wd);
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) chk($sformatf("vec%0d_wdata", i), 32'(wd), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_w", i), 32'(w_reg), 32'(vecs[i].exp_w));
      chk($sformatf("vec%0d_c", i), 32'(status_c), 32'(vecs[i].exp_c));
      chk($sformatf("vec%0d_z", i), 32'(status_z), 32'(vecs[i].exp_z));
      if (vecs[i].chk_dc) chk($sformatf("vec%0d_dc", i), 32'(status_dc), 32'(vecs[i].exp_dc));
    end

    // Reset landing on the EXE->WB edge of INCF d=0 must abort the retire
    do_reset();
    bus.instr = {INCF, 1'b0, 7'h30};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    bus.f_rdata = 8'h41;
    @(negedge clk);
    chk("abort_exe_mux_a", 32'(op_mux_a), 2);
    alu_result = 8'h42; C_new = 1'b1; DC_new = 1'b1; Z_new = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(done), 0);
    chk("abort_f_we", 32'(bus.f_we), 0);
    chk("abort_w", 32'(w_reg), 0);
    chk("abort_ready", 32'(bus.instr_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(bus.instr_ready), 1);
    chk("abort_done_after", 32'(done), 0);
    chk("abort_flags", 32'({status_c, status_dc, status_z}), 0);

    // instr_valid held high: a transfer every fifth cycle
    m_mem[7'h31] = 8'h00;
    bus.f_rdata = 8'h00;
    alu_result = 8'h00; C_new = 1'b1; DC_new = 1'b1; Z_new = 1'b1;
    bus.instr = {MOVF, 1'b0, 7'h31};
    bus.instr_valid = 1'b1;
    dones = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) bus.instr_valid = 1'b0;
      if (bus.instr_valid && bus.instr_ready) xfer.push_back(k);
      if (done) dones++;
      if (k < 20) @(negedge clk);
    end
    chk("b2b_count", 32'(xfer.size()), 4);
    for (int i = 0; i < xfer.size(); i++) chk($sformatf("b2b_xfer%0d", i), 32'(xfer[i]), 32'(5 * i));
    chk("b2b_dones", 32'(dones), 4);
    chk("b2b_ready_end", 32'(bus.instr_ready), 1);
    m_w = 8'h00; m_z = 1'b1;
    chk("b2b_w", 32'(w_reg), 32'(m_w));
    chk("b2b_status", 32'({status_c, status_dc, status_z}), 32'({m_c, m_dc, m_z}));

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 12)] : 6'($urandom);
      ins = {op, 1'($urandom), 7'($urandom)};
      m_mem[ins[6:0]] = 8'($urandom);
      exec(ins, we, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
